// File: rtl/setup_packet_tx_pkg.sv
// Shared types and constants for the USB SETUP packet transmitter.
// CRC states are present only when SETUP_PACKET_TX_CRC16_EN is defined.
package setup_packet_tx_pkg;

   localparam int unsigned SETUP_PKT_LEN  = 8;
   localparam logic [15:0] USB_CRC16_INIT = 16'hFFFF;

   typedef enum logic {
      DTD_HOST_TO_DEVICE = 1'b0,
      DTD_DEVICE_TO_HOST = 1'b1
   } SetupRequestTypeDTD;

   typedef enum logic [1:0] {
      TYPE_STANDARD = 2'd0,
      TYPE_CLASS    = 2'd1,
      TYPE_VENDOR   = 2'd2,
      TYPE_RESERVED = 2'd3
   } SetupRequestTypeType;

   typedef enum logic [4:0] {
      RCPT_DEVICE    = 5'd0,
      RCPT_INTERFACE = 5'd1,
      RCPT_ENDPOINT  = 5'd2,
      RCPT_OTHER     = 5'd3
   } SetupRequestTypeRecipient;

   typedef enum logic [7:0] {
      REQ_GET_STATUS        = 8'd0,
      REQ_CLEAR_FEATURE     = 8'd1,
      REQ_SET_FEATURE       = 8'd3,
      REQ_SET_ADDRESS       = 8'd5,
      REQ_GET_DESCRIPTOR    = 8'd6,
      REQ_SET_DESCRIPTOR    = 8'd7,
      REQ_GET_CONFIGURATION = 8'd8,
      REQ_SET_CONFIGURATION = 8'd9,
      REQ_GET_INTERFACE     = 8'd10,
      REQ_SET_INTERFACE     = 8'd11,
      REQ_SYNCH_FRAME       = 8'd12
   } SetupRequest;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1
`ifdef SETUP_PACKET_TX_CRC16_EN
      ,
      ST_CRC_LO = 2'd2,
      ST_CRC_HI = 2'd3
`endif
   } SetupTxState;

endpackage

// File: rtl/setup_packet_tx_crc16.sv
// Byte-wide USB CRC16 update step (poly 0x8005, LSB-first).
// Uses the bit-reflected register form, so the 0x8005 polynomial appears as 0xA001.
module usb_crc16 (
   input  logic [15:0] crc_in,
   input  logic [7:0]  data,
   output logic [15:0] crc_out
);

   logic [15:0] w_crc;

   always_comb begin
      w_crc = crc_in;
      for (int unsigned i = 0; i < 8; i++) begin
         if (w_crc[0] ^ data[i]) w_crc = (w_crc >> 1) ^ 16'hA001;
         else                    w_crc = w_crc >> 1;
      end
      crc_out = w_crc;
   end

endmodule

// File: rtl/setup_packet_tx.sv
// Serializes an 8-byte USB SETUP request onto a valid/ready byte stream.
// Define SETUP_PACKET_TX_CRC16_EN to append the two DATA0 CRC16 bytes.
module setup_packet_tx
   import setup_packet_tx_pkg::*;
(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  SetupRequestTypeDTD       bmRequestTypeDPTD,
   input  SetupRequestTypeType      bmRequestTypeType,
   input  SetupRequestTypeRecipient bmRequestTypeRecipient,
   input  SetupRequest              bRequest,
   input  logic [15:0]              wValue,
   input  logic [15:0]              wIndex,
   input  logic [15:0]              wLength,
   output logic [7:0]               byte_out,
   output logic                     byte_valid,
   input  logic                     byte_ready,
   output logic                     busy,
   output logic                     done
);

   SetupTxState                    r_state, w_state_next;
   logic [2:0]                     r_idx, w_idx_next, w_idx_inc;
   logic [SETUP_PKT_LEN-1:0][7:0]  r_shadow, w_shadow_next, w_fields;
   logic [7:0]                     r_byte_out, w_byte_out_next;
   logic                           r_byte_valid, w_valid_next;
   logic                           r_busy, w_busy_next;
   logic                           r_done, w_done_next;
   logic                           w_xfer;
`ifdef SETUP_PACKET_TX_CRC16_EN
   logic [15:0]                    r_crc, w_crc_next, w_crc_upd;

   usb_crc16 u_crc (
      .crc_in  (r_crc),
      .data    (r_byte_out),
      .crc_out (w_crc_upd)
   );
`endif

   assign w_fields = {wLength[15:8], wLength[7:0], wIndex[15:8], wIndex[7:0],
                      wValue[15:8], wValue[7:0], bRequest,
                      bmRequestTypeDPTD, bmRequestTypeType, bmRequestTypeRecipient};
   assign w_xfer    = r_byte_valid & byte_ready;
   assign w_idx_inc = r_idx + 3'd1;

   // Next-cycle output values are computed here and registered, keeping
   // byte_ready off any combinational path to the outputs.
   always_comb begin
      w_state_next    = r_state;
      w_idx_next      = r_idx;
      w_shadow_next   = r_shadow;
      w_byte_out_next = r_byte_out;
      w_valid_next    = r_byte_valid;
      w_busy_next     = r_busy;
      w_done_next     = 1'b0;
`ifdef SETUP_PACKET_TX_CRC16_EN
      w_crc_next      = r_crc;
`endif
      case (r_state)
         ST_IDLE: begin
            w_valid_next = 1'b0;
            w_busy_next  = 1'b0;
            if (start) begin
               w_state_next    = ST_DATA;
               w_idx_next      = '0;
               w_shadow_next   = w_fields;
               w_byte_out_next = w_fields[0];
               w_valid_next    = 1'b1;
               w_busy_next     = 1'b1;
`ifdef SETUP_PACKET_TX_CRC16_EN
               w_crc_next      = USB_CRC16_INIT;
`endif
            end
         end
         ST_DATA: begin
            if (w_xfer) begin
               w_idx_next = w_idx_inc;
`ifdef SETUP_PACKET_TX_CRC16_EN
               w_crc_next = w_crc_upd;
`endif
               if (r_idx == 3'd7) begin
`ifdef SETUP_PACKET_TX_CRC16_EN
                  w_state_next    = ST_CRC_LO;
                  w_byte_out_next = ~w_crc_upd[7:0];
`else
                  w_state_next = ST_IDLE;
                  w_valid_next = 1'b0;
                  w_busy_next  = 1'b0;
                  w_done_next  = 1'b1;
`endif
               end else begin
                  w_byte_out_next = r_shadow[w_idx_inc];
               end
            end
         end
`ifdef SETUP_PACKET_TX_CRC16_EN
         ST_CRC_LO: begin
            if (w_xfer) begin
               w_state_next    = ST_CRC_HI;
               w_byte_out_next = ~r_crc[15:8];
            end
         end
         ST_CRC_HI: begin
            if (w_xfer) begin
               w_state_next = ST_IDLE;
               w_valid_next = 1'b0;
               w_busy_next  = 1'b0;
               w_done_next  = 1'b1;
            end
         end
`endif
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_idx        <= '0;
         r_shadow     <= '0;
         r_byte_out   <= '0;
         r_byte_valid <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
`ifdef SETUP_PACKET_TX_CRC16_EN
         r_crc        <= USB_CRC16_INIT;
`endif
      end else begin
         r_state      <= w_state_next;
         r_idx        <= w_idx_next;
         r_shadow     <= w_shadow_next;
         r_byte_out   <= w_byte_out_next;
         r_byte_valid <= w_valid_next;
         r_busy       <= w_busy_next;
         r_done       <= w_done_next;
`ifdef SETUP_PACKET_TX_CRC16_EN
         r_crc        <= w_crc_next;
`endif
      end
   end

   assign byte_out   = r_byte_out;
   assign byte_valid = r_byte_valid;
   assign busy       = r_busy;
   assign done       = r_done;

endmodule

// File: tb/tb_setup_packet_tx.sv
// Randomized self-checking bench for setup_packet_tx against a byte-list model.
module tb_setup_packet_tx;
   import setup_packet_tx_pkg::*;

`ifdef SETUP_PACKET_TX_CRC16_EN
   localparam int PKT_BYTES = 10;
`else
   localparam int PKT_BYTES = 8;
`endif

   logic                     clk = 1'b0;
   logic                     reset, start, byte_ready;
   SetupRequestTypeDTD       dptd;
   SetupRequestTypeType      rtype;
   SetupRequestTypeRecipient recip;
   SetupRequest              breq;
   logic [15:0]              wvalue, windex, wlength;
   logic [7:0]               byte_out;
   logic                     byte_valid, busy, done;

   logic [7:0] exp_b [PKT_BYTES];
   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   setup_packet_tx dut (
      .clk                    (clk),
      .reset                  (reset),
      .start                  (start),
      .bmRequestTypeDPTD      (dptd),
      .bmRequestTypeType      (rtype),
      .bmRequestTypeRecipient (recip),
      .bRequest               (breq),
      .wValue                 (wvalue),
      .wIndex                 (windex),
      .wLength                (wlength),
      .byte_out               (byte_out),
      .byte_valid             (byte_valid),
      .byte_ready             (byte_ready),
      .busy                   (busy),
      .done                   (done)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_fields();
      dptd    = SetupRequestTypeDTD'(1'($urandom));
      rtype   = SetupRequestTypeType'(2'($urandom));
      recip   = SetupRequestTypeRecipient'(5'($urandom));
      breq    = SetupRequest'(8'($urandom));
      wvalue  = 16'($urandom);
      windex  = 16'($urandom);
      wlength = 16'($urandom);
   endtask

   // Reference: payload bytes from field arithmetic; CRC computed in the
   // non-reflected shift-left form with poly 0x8005, data fed LSB first.
   task automatic model_packet();
      int unsigned d [8];
      logic [15:0] r, c;
      logic        fb;
      d[0] = (int'(dptd) << 7) | (int'(rtype) << 5) | int'(recip);
      d[1] = int'(breq);
      d[2] = wvalue % 256;  d[3] = wvalue / 256;
      d[4] = windex % 256;  d[5] = windex / 256;
      d[6] = wlength % 256; d[7] = wlength / 256;
      r = 16'hFFFF;
      for (int i = 0; i < 8; i++) begin
         exp_b[i] = 8'(d[i]);
         for (int b = 0; b < 8; b++) begin
            fb = ((d[i] >> b) & 1) != (int'(r[15]));
            r  = r << 1;
            if (fb) r = r ^ 16'h8005;
         end
      end
      c = ~r;
`ifdef SETUP_PACKET_TX_CRC16_EN
      for (int k = 0; k < 8; k++) begin
         exp_b[8][k] = c[15-k];
         exp_b[9][k] = c[7-k];
      end
`else
      if (c == 16'h0) exp_b[0] = exp_b[0];
`endif
   endtask

   task automatic launch();
      model_packet();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // mode 0: ready held high, 1: ready 1,0,0 repeating, 2: random ready.
   // poke: at N+2 pulse start with new fields and force wLength=FFFF.
   task automatic stream(input int mode, input bit poke, output int cycles);
      int pos = 0;
      cycles = 0;
      while (pos < PKT_BYTES && cycles < 200) begin
         case (mode)
            0:       byte_ready = 1'b1;
            1:       byte_ready = (cycles % 3 == 0);
            default: byte_ready = 1'($urandom);
         endcase
         if (poke && cycles == 1) begin
            rand_fields();
            wlength = 16'hFFFF;
            start   = 1'b1;
         end
         if (poke && cycles == 2) start = 1'b0;
         check("valid_mid", byte_valid, 1);
         check("busy_mid", busy, 1);
         check("done_mid", done, 0);
         check($sformatf("byte%0d", pos), byte_out, exp_b[pos]);
         if (byte_ready) pos++;
         tick();
         cycles++;
      end
      start      = 1'b0;
      byte_ready = 1'b0;
      if (cycles >= 200) check("stream_timeout", 1, 0);
      check("done_pulse", done, 1);
      check("busy_done", busy, 0);
      check("valid_done", byte_valid, 0);
   endtask

   initial begin
      int cyc, mode;
      reset = 1'b1; start = 1'b0; byte_ready = 1'b0;
      rand_fields();
      tick(); tick();
      check("rst_byte", byte_out, 0);
      check("rst_valid", byte_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      reset = 1'b0;
      tick();
      check("idle_valid", byte_valid, 0);

      // GET_DESCRIPTOR(Device) against literal bytes.
      dptd = DTD_DEVICE_TO_HOST; rtype = TYPE_STANDARD; recip = RCPT_DEVICE;
      breq = REQ_GET_DESCRIPTOR; wvalue = 16'h0100; windex = 16'h0000; wlength = 16'h0040;
      launch();
      exp_b[0] = 8'h80; exp_b[1] = 8'h06; exp_b[2] = 8'h00; exp_b[3] = 8'h01;
      exp_b[4] = 8'h00; exp_b[5] = 8'h00; exp_b[6] = 8'h40; exp_b[7] = 8'h00;
`ifdef SETUP_PACKET_TX_CRC16_EN
      exp_b[8] = 8'hDD; exp_b[9] = 8'h94;
`endif
      stream(0, 1'b0, cyc);
      check("gd_latency", cyc, PKT_BYTES);
      tick();
      check("no_second_done", done, 0);

      // Same request via the model, with a mid-packet start and wLength change.
      dptd = DTD_DEVICE_TO_HOST; rtype = TYPE_STANDARD; recip = RCPT_DEVICE;
      breq = REQ_GET_DESCRIPTOR; wvalue = 16'h0100; windex = 16'h0000; wlength = 16'h0040;
      launch();
      check("model_b6", exp_b[6], 8'h40);
      stream(1, 1'b1, cyc);
      tick();
      check("poke_no_done", done, 0);

      rand_fields();
      launch();
      for (int p = 0; p < 16; p++) begin
         mode = int'($urandom_range(0, 2));
         stream(mode, 1'($urandom), cyc);
         if (mode == 0) check("latency", cyc, PKT_BYTES);
         if ($urandom_range(0, 1) == 1) begin
            rand_fields();
            launch();
         end else begin
            tick();
            check("done_once", done, 0);
            rand_fields();
            launch();
         end
      end

      // Abort the pending packet after 3 transfers.
      byte_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("pre_rst_byte%0d", i), byte_out, exp_b[i]);
         tick();
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("abort_valid", byte_valid, 0);
      check("abort_busy", busy, 0);
      check("abort_byte", byte_out, 0);
      check("abort_done", done, 0);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("abort_stays_idle", byte_valid, 0);
      end
      rand_fields();
      launch();
      stream(0, 1'b0, cyc);
      check("post_rst_latency", cyc, PKT_BYTES);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
